imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot/programming controller for the pipelined core's word-addressed instruction memory.
- Receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words, and sequences the memory write port (InstWrite/WriteInst/WriteAdress).
- Holds the core in reset while loading, then releases it with a one-cycle decode flush.
- Sits between the serial front end, the instruction memory and the core's reset/hazard path.

Parameters:
- ADDR_WIDTH, 12, word-address width of instruction memory; capacity 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word aligned.
- TIMEOUT_CYCLES, 1000000, maximum clock cycles allowed between accepted bytes; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load session
- rx_valid  in  1  byte available
- rx_data  in  8  byte value
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- InstWrite  out  1  memory write strobe
- WriteInst  out  32  write data
- WriteAdress  out  32  write byte address
- imem_stall  out  1  StallD to memory while loader_sel=1
- imem_flush  out  1  FlushD to memory while loader_sel=1
- loader_sel  out  1  1 = memory StallD/FlushD are driven by the loader, not by core hazard logic
- core_reset_n  out  1  active-low reset to the core
- busy  out  1  session in progress
- done  out  1  sticky: last session completed
- error  out  1  sticky: last session failed

Behaviour:
- Clock and reset: all state on posedge clk; reset_n asynchronous, active-low.
- Reset values: state=IDLE; InstWrite=0; WriteInst=0; WriteAdress=BASE_ADDR; rx_ready=0; imem_stall=0; imem_flush=0; loader_sel=0; core_reset_n=0; busy=0; done=0; error=0. core_reset_n rises on the first clock edge in IDLE after reset release, so the core runs the preloaded image.
- States: IDLE, LEN, DATA, WRITE, CHK, RELEASE, ERR.
- IDLE: core_reset_n=1, rx_ready=0. On start: clear done/error, busy=1, loader_sel=1, core_reset_n=0, word index=0, go to LEN. Bytes arriving while in IDLE are not accepted.
- LEN: rx_ready=1. Accept 4 bytes, LSB first, into a 32-bit count N.
  - N=0: go to RELEASE (nothing written).
  - N>2^ADDR_WIDTH: go to ERR.
  - Otherwise: go to DATA.
- DATA: rx_ready=1. Assemble 4 bytes LSB first; the 4th accepted byte moves to WRITE the next cycle.
- WRITE: exactly one cycle.
  - InstWrite=1; WriteInst=assembled word; WriteAdress=BASE_ADDR+4*index.
  - imem_stall=0, imem_flush=0 so the write is not blocked by the memory's stall/flush priority.
  - rx_ready=0.
  - index+1: if it equals N, go to CHK (macro defined) or RELEASE; else go to DATA.
- InstWrite is 0 in every other state. WriteAdress/WriteInst hold their last values.
- RELEASE: one cycle. imem_flush=1, done=1; next cycle go to IDLE with busy=0, loader_sel=0, core_reset_n=1.
- ERR: error=1, busy=0, rx_ready=0, core_reset_n=0, loader_sel=1, imem_flush=0. Held until start (restart a session to LEN) or reset.
- Timeout: the gap counter resets on every accepted byte and on state entry. Reaching TIMEOUT_CYCLES while in LEN, DATA or CHK goes to ERR.
- start while busy or in RELEASE: ignored.
- Byte handshake: a handshake in the same cycle as the state exit is consumed by the exited state only.
- Address arithmetic: modulo 2^32, no carry out.
- Reset mid-session: immediate return to reset values. Partially written memory is not restored.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, enter CHK (rx_ready=1) and accept 4 bytes LSB first.
  - Compare against the mod-2^32 sum of all written words.
  - Match: go to RELEASE.
  - Mismatch: go to ERR.
  - N=0 still goes straight to RELEASE with no checksum bytes.
- Undefined: CHK state and sum accumulator are absent; the last WRITE goes to RELEASE.

Test Plan:
- Load 2 words: reset, start, send bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00 -> InstWrite pulses with (0x00, 0x00A00513) then (0x04, 0x00B00593); imem_flush=1 one cycle; done=1; core_reset_n=1.
- N=0: start, send 00 00 00 00 -> no InstWrite; done=1 within 2 cycles of the 4th byte.
- Oversize: ADDR_WIDTH=2, send N=5 -> error=1, core_reset_n=0, rx_ready=0; a following start re-enters LEN.
- Timeout: TIMEOUT_CYCLES=16; stop after 2 data bytes -> error=1 at the 16th idle cycle; no InstWrite seen.
- Reset mid-session: assert reset_n=0 during DATA -> all outputs at reset values in the same cycle; after release core_reset_n=1 next edge.
- With IMEM_LOADER_CHECKSUM_EN: 1 word 0x00000013, checksum 13 00 00 00 -> done=1; checksum 14 00 00 00 -> error=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into instruction-memory writes, holding the core in reset.
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        InstWrite,
  output logic [31:0] WriteInst,
  output logic [31:0] WriteAdress,
  output logic        imem_stall,
  output logic        imem_flush,
  output logic        loader_sel,
  output logic        core_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    RELEASE, ERR
  } state_t;

  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  state_t              state, state_nxt;
  logic [1:0]          bcnt;
  logic [23:0]         sh;
  logic [31:0]         nwords;
  logic [ADDR_WIDTH:0] idx;
  logic [31:0]         gap;
  logic [31:0]         word;
  logic                accept, last_byte, timeout, idx_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         sum;
  assign rx_ready = (state == LEN) || (state == DATA) || (state == CHK);
`else
  assign rx_ready = (state == LEN) || (state == DATA);
`endif

  assign accept    = rx_valid && rx_ready;
  assign word      = {rx_data, sh};
  assign last_byte = accept && (bcnt == 2'd3);
  // Gap counter only runs in byte-receiving states; an accepted byte wins over an expiring timer.
  assign timeout   = (TIMEOUT_CYCLES != 0) && rx_ready && !accept &&
                     (gap == 32'(TIMEOUT_CYCLES - 1));
  assign idx_last  = (32'(idx) + 32'd1) == nwords;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    InstWrite  = 1'b0;
    imem_stall = 1'b0;
    imem_flush = 1'b0;
    busy       = 1'b1;
    loader_sel = 1'b1;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        loader_sel = 1'b0;
        if (start) state_nxt = LEN;
      end
      LEN: begin
        imem_stall = 1'b1;
        if (last_byte) begin
          if (word == 32'd0)            state_nxt = RELEASE;
          else if ({1'b0, word} > CAP)  state_nxt = ERR;
          else                          state_nxt = DATA;
        end else if (timeout) state_nxt = ERR;
      end
      DATA: begin
        imem_stall = 1'b1;
        if (last_byte)    state_nxt = WRITE;
        else if (timeout) state_nxt = ERR;
      end
      WRITE: begin
        InstWrite = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_nxt = idx_last ? CHK : DATA;
`else
        state_nxt = idx_last ? RELEASE : DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        imem_stall = 1'b1;
        if (last_byte)    state_nxt = (word == sum) ? RELEASE : ERR;
        else if (timeout) state_nxt = ERR;
      end
`endif
      RELEASE: begin
        imem_flush = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        busy       = 1'b0;
        imem_stall = 1'b1;
        if (start) state_nxt = LEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt         <= '0;
      sh           <= '0;
      nwords       <= '0;
      idx          <= '0;
      gap          <= '0;
      WriteInst    <= '0;
      WriteAdress  <= BASE_ADDR;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      if (accept) begin
        sh   <= word[31:8];
        bcnt <= bcnt + 2'd1;
      end
      if (accept || state_nxt != state) gap <= '0;
      else if (rx_ready)                gap <= gap + 32'd1;
      if (state == LEN && last_byte) nwords <= word;
      if (state == DATA && last_byte) begin
        WriteInst   <= word;
        WriteAdress <= BASE_ADDR + (32'(idx) << 2);
      end
      if (state == WRITE) begin
        idx <= idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum <= sum + WriteInst;
`endif
      end
      if ((state == IDLE || state == ERR) && start) begin
        done         <= 1'b0;
        error        <= 1'b0;
        idx          <= '0;
        bcnt         <= '0;
        core_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum          <= '0;
`endif
      end else if (state == IDLE || state == RELEASE) begin
        core_reset_n <= 1'b1;
      end
      if (state_nxt == RELEASE && state != RELEASE) done  <= 1'b1;
      if (state_nxt == ERR && state != ERR)         error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, corner-case sequences, and randomized sessions vs a session model.
module tb_imem_loader;
  localparam int          AW   = 2;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CAP  = 1 << AW;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, InstWrite, imem_stall, imem_flush, loader_sel;
  logic        core_reset_n, busy, done, error;
  logic [31:0] WriteInst, WriteAdress;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .InstWrite(InstWrite), .WriteInst(WriteInst), .WriteAdress(WriteAdress),
    .imem_stall(imem_stall), .imem_flush(imem_flush), .loader_sel(loader_sel),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [63:0] wlog [0:1023];
  int w_cnt = 0, f_cnt = 0;

  always @(negedge clk) begin
    if (InstWrite && w_cnt < 1024) begin
      wlog[w_cnt] <= {WriteAdress, WriteInst};
      w_cnt <= w_cnt + 1;
    end
    if (imem_flush) f_cnt <= f_cnt + 1;
  end

  typedef struct {
    logic [31:0] n;
    logic [31:0] w [4];
    logic        ed, ee;
    int          nwr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int t = 0;
    repeat ($urandom_range(0, gmax)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && t < 100) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_ready_wait: got 0 expected 1 within 100 cycles");
      rx_valid = 1'b0;
    end else begin
      @(posedge clk); #1 rx_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], gmax);
  endtask

  // Session-level reference: how many words land in memory, and whether it ends in done or error.
  task automatic run_session(input string name, input logic [31:0] n, input logic [31:0] w [4],
                             input logic bad_ck, input int gmax,
                             input logic ed, input logic ee, input int nwr);
    int w0, f0, t;
    logic [31:0] sum;
    w0 = w_cnt; f0 = f_cnt; sum = 0;
    pulse_start();
    send_word(n, gmax);
    if (n >= 1 && n <= CAP) begin
      for (int i = 0; i < int'(n); i++) begin
        send_word(w[i], gmax);
        sum += w[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(bad_ck ? sum + 32'd1 : sum, gmax);
`endif
    end
    t = 0;
    while (!(done || error) && t < 30) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk({name, ".done"},  done,  ed);
    chk({name, ".error"}, error, ee);
    chk({name, ".nwr"},   w_cnt - w0, nwr);
    for (int i = 0; i < nwr && i < 4; i++)
      chk({name, ".write"}, wlog[w0 + i], {BASE + 32'(4 * i), w[i]});
    chk({name, ".flush"},   f_cnt - f0, ed ? 1 : 0);
    chk({name, ".core_rn"}, core_reset_n, ed);
    chk({name, ".sel"},     loader_sel, ee);
    chk({name, ".busy_rdy"}, {busy, rx_ready}, 2'b00);
  endtask

  vec_t vtab [6];

  initial begin
    vtab[0].n = 2;            vtab[0].w = '{32'h00A00513, 32'h00B00593, 0, 0};
    vtab[0].ed = 1; vtab[0].ee = 0; vtab[0].nwr = 2;
    vtab[1].n = 0;            vtab[1].w = '{0, 0, 0, 0};
    vtab[1].ed = 1; vtab[1].ee = 0; vtab[1].nwr = 0;
    vtab[2].n = 5;            vtab[2].w = '{0, 0, 0, 0};
    vtab[2].ed = 0; vtab[2].ee = 1; vtab[2].nwr = 0;
    vtab[3].n = 1;            vtab[3].w = '{32'hDEADBEEF, 0, 0, 0};
    vtab[3].ed = 1; vtab[3].ee = 0; vtab[3].nwr = 1;
    vtab[4].n = 4;            vtab[4].w = '{32'h11111111, 32'h80000000, 32'hFFFFFFFF, 32'h0000A5A5};
    vtab[4].ed = 1; vtab[4].ee = 0; vtab[4].nwr = 4;
    vtab[5].n = 32'h01000001; vtab[5].w = '{0, 0, 0, 0};
    vtab[5].ed = 0; vtab[5].ee = 1; vtab[5].nwr = 0;

    // Reset values while reset_n is held low
    #1;
    chk("rst.flags", {InstWrite, rx_ready, imem_stall, imem_flush, loader_sel, core_reset_n, busy, done, error}, 9'b0);
    chk("rst.addr",  WriteAdress, BASE);
    chk("rst.data",  WriteInst, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1 chk("rst.core_rn_hold", core_reset_n, 1'b0);
    @(posedge clk); #1 chk("rst.core_rn_rise", core_reset_n, 1'b1);

    for (int i = 0; i < 6; i++)
      run_session($sformatf("vec%0d", i), vtab[i].n, vtab[i].w, 1'b0, 1, vtab[i].ed, vtab[i].ee, vtab[i].nwr);

    // N=0: done within two cycles of the last length byte
    begin
      int k = 0;
      pulse_start();
      send_word(32'd0, 0);
      while (!done && k < 2) begin @(posedge clk); #1 k++; end
      chk("n0.done_lat", done, 1'b1);
      repeat (3) @(negedge clk);
    end

    // Oversize then restart from ERR back into LEN
    begin
      logic [31:0] z [4];
      z = '{0, 0, 0, 0};
      run_session("over", 32'd5, z, 1'b0, 0, 1'b0, 1'b1, 0);
      pulse_start();
      chk("over.restart", {busy, rx_ready, error, core_reset_n}, 4'b1100);
      send_word(32'd0, 0);
      repeat (3) @(negedge clk);
      chk("over.recover", {done, error}, 2'b10);
    end

    // Timeout after two data bytes
    begin
      int w0;
      w0 = w_cnt;
      pulse_start();
      send_word(32'd2, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      repeat (TO - 1) @(posedge clk);
      #1 chk("to.before", error, 1'b0);
      @(posedge clk); #1 chk("to.at", error, 1'b1);
      chk("to.state", {core_reset_n, rx_ready, busy}, 3'b000);
      chk("to.nwr", w_cnt - w0, 0);
    end

    // Asynchronous reset in the middle of DATA
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    send_byte(8'hAA, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid.flags", {InstWrite, rx_ready, imem_stall, imem_flush, loader_sel, core_reset_n, busy, done, error}, 9'b0);
    chk("mid.addr_data", {WriteAdress, WriteInst}, {BASE, 32'd0});
    @(negedge clk); reset_n = 1'b1;
    #1 chk("mid.core_rn_hold", core_reset_n, 1'b0);
    @(posedge clk); #1 chk("mid.core_rn_rise", core_reset_n, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [31:0] c [4];
      c = '{32'h00000013, 0, 0, 0};
      run_session("ck_good", 32'd1, c, 1'b0, 0, 1'b1, 1'b0, 1);
      run_session("ck_bad",  32'd1, c, 1'b1, 0, 1'b0, 1'b1, 1);
    end
`endif

    // Randomized sessions against the session model
    for (int it = 0; it < 24; it++) begin
      logic [31:0] n;
      logic [31:0] w [4];
      logic bad, ee;
      int nwr;
      n = $urandom_range(0, CAP + 1);
      if ($urandom_range(0, 7) == 0) n = $urandom | 32'h100;
      for (int j = 0; j < 4; j++) w[j] = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
      ee  = (n > CAP) || (bad && n != 0);
`else
      bad = 1'b0;
      ee  = (n > CAP);
`endif
      nwr = (n > CAP) ? 0 : int'(n);
      run_session($sformatf("rnd%0d", it), n, w, bad, 3, !ee, ee, nwr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
